fb_port_arbiter: RTL

Arbiter and sequencer for the single-port frame-buffer line RAM shared by the PAL video line fetcher and the UART pixel writer. Video reads have hard per-line deadlines and normally win. A starvation counter guarantees UART writes progress when video is not urgent. The block owns every RAM command and returns the fetched line in a held output register.

---
 rtl/fb_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Frame-buffer line RAM arbiter: video reads normally win, UART writes are
// protected from starvation by a saturating wait counter. All outputs registered.
module fb_port_arbiter #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 300,
    parameter int DEPTH           = 608,
    parameter int WR_STARVE_LIMIT = 64
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_VID_REQ,
    input  logic              i_VID_URGENT,
    input  logic [ADDR_W-1:0] i_VID_ADDR,
    output logic              o_VID_ACK,
    output logic              o_VID_VALID,
    output logic [DATA_W-1:0] o_VID_LINE,
    input  logic              i_WR_REQ,
    input  logic [ADDR_W-1:0] i_WR_ADDR,
    input  logic [DATA_W-1:0] i_WR_DATA,
    output logic              o_WR_ACK,
    output logic              o_WR_ERR,
    output logic              o_RAM_EN,
    output logic              o_RAM_WE,
    output logic [ADDR_W-1:0] o_RAM_ADDR,
    output logic [DATA_W-1:0] o_RAM_WDATA,
    input  logic [DATA_W-1:0] i_RAM_RDATA,
    output logic              o_BUSY
);

    localparam int WAIT_W = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WR_STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD     = 2'd1,
        S_RD_CAP = 2'd2,
        S_WR     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wr_wait_q, wr_wait_d;
    logic              rd_oor_q, rd_oor_d;
    logic              vid_ack_q, vid_ack_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_line_q, vid_line_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q, busy_d;
    logic              wr_pick;
    logic              vid_in_range;
    logic              wr_in_range;

    assign vid_in_range = int'(i_VID_ADDR) < DEPTH;
    assign wr_in_range  = int'(i_WR_ADDR) < DEPTH;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q     <= S_IDLE;
            wr_wait_q   <= '0;
            rd_oor_q    <= 1'b0;
            vid_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_line_q  <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_wait_q   <= wr_wait_d;
            rd_oor_q    <= rd_oor_d;
            vid_ack_q   <= vid_ack_d;
            vid_valid_q <= vid_valid_d;
            vid_line_q  <= vid_line_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // A starved write only pre-empts video when video is not close to its deadline.
    assign wr_pick = (wr_wait_q == WAIT_MAX) && !i_VID_URGENT;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_VID_REQ && !(i_WR_REQ && wr_pick)) begin
                    state_d = S_RD;
                end else if (i_WR_REQ) begin
                    state_d = S_WR;
                end
            end
            S_RD:     state_d = S_RD_CAP;
            S_RD_CAP: state_d = S_IDLE;
            S_WR:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        wr_wait_d = wr_wait_q;
        if (!i_WR_REQ || state_d == S_WR) begin
            wr_wait_d = '0;
        end else if (wr_wait_q != WAIT_MAX) begin
            wr_wait_d = wr_wait_q + WAIT_W'(1);
        end
    end

    // Outputs are computed from the next state so they line up with the state they describe.
    always_comb begin
        vid_ack_d   = (state_d == S_RD);
        wr_ack_d    = (state_d == S_WR);
        busy_d      = (state_d != S_IDLE);
        vid_valid_d = (state_q == S_RD_CAP);
        vid_line_d  = vid_line_q;
        wr_err_d    = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rd_oor_d    = rd_oor_q;

        if (state_q == S_RD_CAP) begin
            vid_line_d = rd_oor_q ? '0 : i_RAM_RDATA;
        end
        if (state_d == S_RD) begin
            ram_addr_d = i_VID_ADDR;
            ram_en_d   = vid_in_range;
            rd_oor_d   = !vid_in_range;
        end
        if (state_d == S_WR) begin
            ram_addr_d  = i_WR_ADDR;
            ram_wdata_d = i_WR_DATA;
            ram_we_d    = 1'b1;
            ram_en_d    = wr_in_range;
            wr_err_d    = !wr_in_range;
        end
    end

    assign o_VID_ACK   = vid_ack_q;
    assign o_VID_VALID = vid_valid_q;
    assign o_VID_LINE  = vid_line_q;
    assign o_WR_ACK    = wr_ack_q;
    assign o_WR_ERR    = wr_err_q;
    assign o_RAM_EN    = ram_en_q;
    assign o_RAM_WE    = ram_we_q;
    assign o_RAM_ADDR  = ram_addr_q;
    assign o_RAM_WDATA = ram_wdata_q;
    assign o_BUSY      = busy_q;

endmodule
